decode_lsp_scalar_index: RTL and testbench
==========================================

DECODE_LSP_SCALAR_INDEX -- requirements
Module: decode_lsp_scalar_index

Interface
REQ-001 Parameter N, default 32: data width; all LSP values are signed fixed point, 1 sign, 15 integer, 16 fraction bits.
REQ-002 Parameter Q, default 16: fraction bits.
REQ-003 Parameter HZTORAD, default 32'h00000033: PI/4000 in Q16.16 (51/65536).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start_dlsp  input  1  level request to start decoding; sampled only in IDLE.
REQ-007 in_index0..in_index9  input  4 each  scalar codebook indexes for LSPs 0..9.
REQ-008 out_lsp0..out_lsp9  output  N each  decoded LSPs in radians, Q16.16.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done_dlsp  output  1  one-cycle completion pulse.
REQ-011 range_err  output  1  sticky flag: at least one index was clamped in the current run.

Function
REQ-012 States: IDLE, LATCH, SET_ADDR, ROM_WAIT, CONVERT, DONE.
REQ-013 Transitions: IDLE->LATCH when start_dlsp=1; LATCH->SET_ADDR; SET_ADDR->ROM_WAIT; ROM_WAIT->CONVERT; CONVERT->SET_ADDR if i<9, else DONE; DONE->IDLE.
REQ-014 LATCH registers all ten indexes, clears i to 0, and clears range_err; input changes after this edge do not affect the run.
REQ-015 Codebook sizes m[i] = 16 for i=0..6, 8 for i=7..8, and 4 for i=9.
REQ-016 If a latched index is >= m[i], the block uses m[i]-1 and sets range_err in SET_ADDR of that i.
REQ-017 SET_ADDR drives ROM address {i[3:0], idx[3:0]}; the ROM data is valid in CONVERT.
REQ-018 CONVERT writes out_lsp[i] = (rom_hz * HZTORAD) >> Q using a signed N-bit product, truncated with no rounding, and increments i.
REQ-019 Latency: start is sampled at edge E0; out_lsp[k] updates at edge E0+4+3k; done_dlsp is high from edge E0+32 to edge E0+33.
REQ-020 out_lsp registers hold their values between runs; only CONVERT modifies them.
REQ-021 start_dlsp is ignored while busy=1.
REQ-022 start_dlsp held high through DONE starts a new run at the first IDLE edge (back-to-back runs, 33 cycles apart).
REQ-023 range_err is valid from done_dlsp until the next LATCH.

Reset
REQ-024 While rst=0: state=IDLE, i=0, and all out_lsp, done_dlsp, busy, and range_err are 0.
REQ-025 Reset asserted mid-run aborts the run immediately; no done_dlsp pulse is produced for the aborted run.

Structure
REQ-026 A shared package holds N, Q, HZTORAD, the m[] table, the state encodings, and the LSP codebook contents in Hz (Q16.16).
REQ-027 The block has one sub-module, lsp_cb_rom: 8-bit address, N-bit data, registered output, one-cycle latency, with contents from the shared package.
REQ-028 The multiplication uses the existing qmult #(Q,N) instance; there is one multiplier, time-shared across i.

Verification
REQ-029 All indexes 0, start pulse -> out_lsp0 = 225 Hz x HZTORAD = 32'h00002CD3; done_dlsp high exactly at E0+32 for 1 cycle; range_err=0.
REQ-030 in_index0=15, in_index9=3 -> out_lsp0 = 32'h00007788 (600 Hz), out_lsp9 = 32'h0002B944 (3500 Hz).
REQ-031 in_index9=7, in_index7=12 -> clamped results equal the results for 3 and 7 respectively; range_err=1 at done_dlsp.
REQ-032 Indexes changed, and start_dlsp pulsed, at E0+10 -> outputs match the indexes latched at E0; the second start is ignored; done_dlsp pulses once.
REQ-033 rst=0 at E0+15 -> all outputs are 0 immediately; no done_dlsp; a subsequent start completes normally in 33 cycles.
REQ-034 start_dlsp held high for 70 cycles -> done_dlsp pulses at E0+32 and E0+65; busy is low for exactly one cycle between the runs.

Source files
------------

// File: rtl/decode_lsp_scalar_index_pkg.sv
// Shared definitions for the scalar LSP index decoder.
// Contents: data format constants, the FSM state type, the per-LSP codebook
// sizes and the LSP codebook contents in Hz (Q16.16).
package decode_lsp_scalar_index_pkg;

    localparam int          DLSP_N       = 32;
    localparam int          DLSP_Q       = 16;
    localparam logic [31:0] DLSP_HZTORAD = 32'h0000_0033;  // PI/4000 in Q16.16
    localparam int unsigned NUM_LSP      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SET_ADDR,
        ST_ROM_WAIT,
        ST_CONVERT,
        ST_DONE
    } dlsp_state_t;

    // Number of codebook entries for LSP number lsp.
    function automatic logic [4:0] cb_size(input logic [3:0] lsp);
        logic [4:0] size;
        case (lsp)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: size = 5'd16;
            4'd7, 4'd8:                                 size = 5'd8;
            default:                                    size = 5'd4;
        endcase
        return size;
    endfunction

    // Codebook contents: every table is an arithmetic series, stored here as
    // first entry and spacing in Hz. Address is {lsp[3:0], index[3:0]};
    // unused locations read as zero.
    function automatic logic [31:0] lsp_cb_hz(input logic [7:0] addr);
        int unsigned base;
        int unsigned step;
        int unsigned hz;
        case (addr[7:4])
            4'd0:    begin base = 225;  step = 25;  end
            4'd1:    begin base = 325;  step = 25;  end
            4'd2:    begin base = 500;  step = 50;  end
            4'd3:    begin base = 700;  step = 100; end
            4'd4:    begin base = 950;  step = 100; end
            4'd5:    begin base = 1100; step = 100; end
            4'd6:    begin base = 1500; step = 100; end
            4'd7:    begin base = 2300; step = 100; end
            4'd8:    begin base = 2500; step = 100; end
            4'd9:    begin base = 2900; step = 200; end
            default: begin base = 0;    step = 0;   end
        endcase
        if ({1'b0, addr[3:0]} >= cb_size(addr[7:4]))
            hz = 0;
        else
            hz = base + step * 32'(addr[3:0]);
        return hz << 16;
    endfunction

endpackage

// File: rtl/decode_lsp_scalar_index_rom.sv
// LSP codebook ROM: 8-bit address {lsp, index}, N-bit data, registered
// output with one cycle of latency.
// Ports: clk, addr[7:0], data[N-1:0] (Hz, Q16.16).
module lsp_cb_rom
    import decode_lsp_scalar_index_pkg::*;
#(
    parameter int N = DLSP_N
) (
    input  logic         clk,
    input  logic [7:0]   addr,
    output logic [N-1:0] data
);

    always_ff @(posedge clk) begin
        data <= N'(lsp_cb_hz(addr));
    end

endmodule

// File: rtl/qmult.sv
// Signed fixed-point multiply, Q fraction bits, N-bit operands and result.
// Ports: i_multiplicand, i_multiplier (N-bit signed), o_result (N-bit signed,
// product shifted right by Q, truncated, upper bits discarded).
module qmult #(
    parameter int Q = 15,
    parameter int N = 32
) (
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    output logic [N-1:0] o_result
);

    logic signed [N+Q-1:0] a_ext;
    logic signed [N+Q-1:0] b_ext;
    logic signed [N+Q-1:0] prod;

    assign a_ext    = {{Q{i_multiplicand[N-1]}}, i_multiplicand};
    assign b_ext    = {{Q{i_multiplier[N-1]}}, i_multiplier};
    assign prod     = a_ext * b_ext;
    assign o_result = N'(prod >>> Q);

endmodule

// File: rtl/decode_lsp_scalar_index.sv
// Scalar LSP index decoder: latches ten codebook indexes, looks each up in
// the LSP codebook ROM (clamping out-of-range indexes) and converts Hz to
// radians with one shared multiplier.
// Ports: clk, rst (async, active-low), start_dlsp, in_index0..9 (4-bit),
// out_lsp0..9 (N-bit Q16.16 radians), busy, done_dlsp, range_err.
module decode_lsp_scalar_index
    import decode_lsp_scalar_index_pkg::*;
#(
    parameter int          N       = DLSP_N,
    parameter int          Q       = DLSP_Q,
    parameter logic [N-1:0] HZTORAD = N'(DLSP_HZTORAD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_dlsp,
    input  logic [3:0]   in_index0,
    input  logic [3:0]   in_index1,
    input  logic [3:0]   in_index2,
    input  logic [3:0]   in_index3,
    input  logic [3:0]   in_index4,
    input  logic [3:0]   in_index5,
    input  logic [3:0]   in_index6,
    input  logic [3:0]   in_index7,
    input  logic [3:0]   in_index8,
    input  logic [3:0]   in_index9,
    output logic [N-1:0] out_lsp0,
    output logic [N-1:0] out_lsp1,
    output logic [N-1:0] out_lsp2,
    output logic [N-1:0] out_lsp3,
    output logic [N-1:0] out_lsp4,
    output logic [N-1:0] out_lsp5,
    output logic [N-1:0] out_lsp6,
    output logic [N-1:0] out_lsp7,
    output logic [N-1:0] out_lsp8,
    output logic [N-1:0] out_lsp9,
    output logic         busy,
    output logic         done_dlsp,
    output logic         range_err
);

    dlsp_state_t  state, state_nx;
    logic [3:0]   lsp_i;
    logic [3:0]   idx_q [NUM_LSP];
    logic [N-1:0] lsp_q [NUM_LSP];
    logic         done_q;
    logic         err_q;

    logic [3:0]   idx_raw;
    logic [3:0]   idx_eff;
    logic [4:0]   size;
    logic         clamp;
    logic [7:0]   rom_addr;
    logic [N-1:0] rom_data;
    logic [N-1:0] lsp_rad;

    // The ROM address follows the counter continuously; i is stable from
    // SET_ADDR through CONVERT, so the registered ROM word is valid there.
    always_comb begin
        idx_raw  = idx_q[lsp_i];
        size     = cb_size(lsp_i);
        clamp    = {1'b0, idx_raw} >= size;
        idx_eff  = clamp ? 4'(size - 5'd1) : idx_raw;
        rom_addr = {lsp_i, idx_eff};
    end

    lsp_cb_rom #(.N(N)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    qmult #(.Q(Q), .N(N)) u_mult (
        .i_multiplicand (rom_data),
        .i_multiplier   (HZTORAD),
        .o_result       (lsp_rad)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (start_dlsp) state_nx = ST_LATCH;
            ST_LATCH:    state_nx = ST_SET_ADDR;
            ST_SET_ADDR: state_nx = ST_ROM_WAIT;
            ST_ROM_WAIT: state_nx = ST_CONVERT;
            ST_CONVERT:  state_nx = (lsp_i < 4'd9) ? ST_SET_ADDR : ST_DONE;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsp_i  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int unsigned k = 0; k < NUM_LSP; k++) begin
                idx_q[k] <= '0;
                lsp_q[k] <= '0;
            end
        end else begin
            done_q <= (state == ST_DONE);
            case (state)
                ST_LATCH: begin
                    idx_q[0] <= in_index0;
                    idx_q[1] <= in_index1;
                    idx_q[2] <= in_index2;
                    idx_q[3] <= in_index3;
                    idx_q[4] <= in_index4;
                    idx_q[5] <= in_index5;
                    idx_q[6] <= in_index6;
                    idx_q[7] <= in_index7;
                    idx_q[8] <= in_index8;
                    idx_q[9] <= in_index9;
                    lsp_i    <= '0;
                    err_q    <= 1'b0;
                end
                ST_SET_ADDR: begin
                    if (clamp) err_q <= 1'b1;
                end
                ST_CONVERT: begin
                    lsp_q[lsp_i] <= lsp_rad;
                    lsp_i        <= lsp_i + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done_dlsp = done_q;
    assign range_err = err_q;

    assign out_lsp0 = lsp_q[0];
    assign out_lsp1 = lsp_q[1];
    assign out_lsp2 = lsp_q[2];
    assign out_lsp3 = lsp_q[3];
    assign out_lsp4 = lsp_q[4];
    assign out_lsp5 = lsp_q[5];
    assign out_lsp6 = lsp_q[6];
    assign out_lsp7 = lsp_q[7];
    assign out_lsp8 = lsp_q[8];
    assign out_lsp9 = lsp_q[9];

endmodule

// File: tb/tb_decode_lsp_scalar_index.sv
// Self-checking bench for decode_lsp_scalar_index: table of index sets with
// expected codebook frequencies (Hz) and range flag, plus hand-written
// sequences for latency, input isolation, mid-run reset and back-to-back runs.
module tb_decode_lsp_scalar_index;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  idx [10];
    logic [31:0] lsp [10];
    logic        busy, done, rerr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_lsp_scalar_index #(.N(32), .Q(16), .HZTORAD(32'h0000_0033)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_dlsp (start),
        .in_index0  (idx[0]), .in_index1 (idx[1]), .in_index2 (idx[2]),
        .in_index3  (idx[3]), .in_index4 (idx[4]), .in_index5 (idx[5]),
        .in_index6  (idx[6]), .in_index7 (idx[7]), .in_index8 (idx[8]),
        .in_index9  (idx[9]),
        .out_lsp0   (lsp[0]), .out_lsp1 (lsp[1]), .out_lsp2 (lsp[2]),
        .out_lsp3   (lsp[3]), .out_lsp4 (lsp[4]), .out_lsp5 (lsp[5]),
        .out_lsp6   (lsp[6]), .out_lsp7 (lsp[7]), .out_lsp8 (lsp[8]),
        .out_lsp9   (lsp[9]),
        .busy       (busy),
        .done_dlsp  (done),
        .range_err  (rerr)
    );

    // Packed arrays list element 9 first in the concatenations below.
    typedef struct packed {
        logic [9:0][3:0]  idx;
        logic [9:0][15:0] hz;
        logic             err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_idx(input logic [9:0][3:0] v);
        for (int i = 0; i < 10; i++) idx[i] = v[i];
    endtask

    task automatic chk_outs(input vec_t v, input string tag);
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s lsp%0d", tag, i), lsp[i], 32'(v.hz[i]) * 32'd51);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int done_at;
        int ndone;
        done_at = 0;
        ndone   = 0;
        @(negedge clk);
        apply_idx(v.idx);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (done_at == 0) done_at = k;
            end
            if (k == 32) chk({tag, " range_err"}, 32'(rerr), 32'(v.err));
        end
        chk({tag, " done_at"}, done_at, 32);
        chk({tag, " done_count"}, ndone, 1);
        chk_outs(v, tag);
    endtask

    initial begin
        vecs[0].idx = '0;
        vecs[0].hz  = {16'd2900, 16'd2500, 16'd2300, 16'd1500, 16'd1100,
                       16'd950, 16'd700, 16'd500, 16'd325, 16'd225};
        vecs[0].err = 1'b0;
        vecs[1].idx = {4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
        vecs[1].hz  = {16'd3500, 16'd2500, 16'd2300, 16'd1500, 16'd1100,
                       16'd950, 16'd700, 16'd500, 16'd325, 16'd600};
        vecs[1].err = 1'b0;
        vecs[2].idx = {4'd7, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[2].hz  = {16'd3500, 16'd2500, 16'd3000, 16'd1500, 16'd1100,
                       16'd950, 16'd700, 16'd500, 16'd325, 16'd225};
        vecs[2].err = 1'b1;
        vecs[3].idx = {4'd2, 4'd8, 4'd7, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        vecs[3].hz  = {16'd3300, 16'd3200, 16'd3000, 16'd2200, 16'd1700,
                       16'd1450, 16'd1100, 16'd650, 16'd375, 16'd250};
        vecs[3].err = 1'b1;
        vecs[4].idx = {10{4'd15}};
        vecs[4].hz  = {16'd3500, 16'd3200, 16'd3000, 16'd3000, 16'd2600,
                       16'd2450, 16'd2200, 16'd1250, 16'd700, 16'd600};
        vecs[4].err = 1'b1;
        vecs[5].idx = {4'd3, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[5].hz  = {16'd3500, 16'd3200, 16'd3000, 16'd1500, 16'd1100,
                       16'd950, 16'd700, 16'd500, 16'd325, 16'd225};
        vecs[5].err = 1'b0;
        vecs[6].idx = {4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        vecs[6].hz  = {16'd2900, 16'd2500, 16'd3000, 16'd1500, 16'd1100,
                       16'd950, 16'd700, 16'd500, 16'd325, 16'd225};
        vecs[6].err = 1'b1;

        apply_idx('0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) chk($sformatf("reset lsp%0d", i), lsp[i], 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset range_err", 32'(rerr), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Latency of first and last conversion, done pulse position
        @(negedge clk);
        apply_idx(vecs[0].idx);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)  chk("lat busy E1", 32'(busy), 32'd1);
            if (k == 3)  chk("lat lsp0 E3", lsp[0], 32'd0);
            if (k == 4)  chk("lat lsp0 E4", lsp[0], 32'h0000_2CD3);
            if (k == 30) chk("lat lsp9 E30", lsp[9], 32'd0);
            if (k == 31) chk("lat lsp9 E31", lsp[9], 32'd2900 * 32'd51);
            if (k == 31) chk("lat done E31", 32'(done), 32'd0);
            if (k == 32) chk("lat done E32", 32'(done), 32'd1);
            if (k == 32) chk("lat busy E32", 32'(busy), 32'd0);
            if (k == 32) chk("lat range_err", 32'(rerr), 32'd0);
            if (k == 33) chk("lat done E33", 32'(done), 32'd0);
        end

        // Table-driven runs
        for (int v = 0; v < 7; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Input changes and a second start mid-run are ignored
        begin
            int ndone;
            int done_at;
            ndone   = 0;
            done_at = 0;
            @(negedge clk);
            apply_idx(vecs[1].idx);
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            for (int k = 1; k <= 45; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) begin
                    ndone++;
                    if (done_at == 0) done_at = k;
                end
                if (k == 9) begin
                    apply_idx(vecs[4].idx);
                    start = 1'b1;
                end
                if (k == 10) start = 1'b0;
            end
            chk("iso done_count", ndone, 1);
            chk("iso done_at", done_at, 32);
            chk("iso busy_after", 32'(busy), 32'd0);
            chk_outs(vecs[1], "iso");
        end

        // Reset mid-run
        begin
            int ndone;
            ndone = 0;
            @(negedge clk);
            apply_idx(vecs[4].idx);
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat (15) @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            for (int i = 0; i < 10; i++) chk($sformatf("abort lsp%0d", i), lsp[i], 32'd0);
            chk("abort busy", 32'(busy), 32'd0);
            chk("abort done", 32'(done), 32'd0);
            chk("abort range_err", 32'(rerr), 32'd0);
            @(negedge clk);
            rst = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) ndone++;
            end
            chk("abort no_done", ndone, 0);
            run_vec(vecs[2], "post_abort");
        end

        // start held high: back-to-back runs
        begin
            int d [3];
            int ndone;
            int busy_low;
            ndone    = 0;
            busy_low = 0;
            for (int j = 0; j < 3; j++) d[j] = 0;
            @(negedge clk);
            apply_idx(vecs[3].idx);
            start = 1'b1;
            @(posedge clk);
            for (int k = 1; k <= 105; k++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) begin
                    if (ndone < 3) d[ndone] = k;
                    ndone++;
                end
                if (k <= 64 && busy !== 1'b1) busy_low++;
                if (k == 70) start = 1'b0;
            end
            chk("b2b done_count", ndone, 3);
            chk("b2b done1", d[0], 32);
            chk("b2b done2", d[1], 65);
            chk("b2b done3", d[2], 98);
            chk("b2b busy_low", busy_low, 1);
            chk("b2b range_err", 32'(rerr), 32'd1);
            chk_outs(vecs[3], "b2b");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
